// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-to-memory bus bridge.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  localparam logic [2:0]  FC_CPU_SPACE    = 3'b111;
  localparam logic [15:0] BERR_RDATA      = 16'hFFFF;
  localparam int          TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on memory; expired flags the last allowed cycle.
module bus_timeout_counter
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  // Holds at the last count rather than wrapping if the owner stays enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST_COUNT)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/m68k_bus_bridge.sv
// Bridges 68000 strobed bus cycles onto a req/ack memory port, stalling the CPU
// through cpu_clk_en and raising a bus error on CPU-space cycles or timeout.
//
//   state   | meaning
//   IDLE    | waiting for a CPU access; CPU runs unless one is presented
//   WAIT    | memory request outstanding; CPU stalled
//   DONE    | one-cycle CPU release, with bus error if the access failed
module m68k_bus_bridge
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cpu_addr,
  input  logic [2:0]        cpu_fc,
  input  logic [15:0]       cpu_wdata,
  input  logic              cpu_uds,
  input  logic              cpu_lds,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_clk_en,
  output logic              cpu_berr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  bus_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_berr_q, cpu_berr_d;

  logic access;
  logic expired;
  logic unused_addr_bits;

  assign access = (~cpu_uds | ~cpu_lds) & (cpu_read ^ cpu_write);
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], cpu_addr[0]};

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_berr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (cpu_fc == FC_CPU_SPACE) begin
            state_d    = ST_DONE;
            cpu_berr_d = 1'b1;
          end else begin
            state_d     = ST_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_write;
            mem_addr_d  = cpu_addr[ADDR_W-1:1];
            mem_be_d    = {~cpu_uds, ~cpu_lds};
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ST_WAIT: begin
        // An ack landing on the expiry cycle still completes normally.
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end else if (expired) begin
          state_d     = ST_DONE;
          mem_req_d   = 1'b0;
          cpu_rdata_d = BERR_RDATA;
          cpu_berr_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_berr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_berr_q  <= cpu_berr_d;
    end
  end

  // The CPU must see an immediate stall when it starts a cycle, so this is
  // decoded from the live access term rather than registered; reset holds it low.
  assign cpu_clk_en = reset_n & (((state_q == ST_IDLE) & ~access) | (state_q == ST_DONE));

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_berr  = cpu_berr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Directed bench for m68k_bus_bridge: a transaction-level model predicts every
// output each cycle, plus literal spot checks on the key scenarios.
module tb_m68k_bus_bridge;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic [2:0]  cpu_fc;
  logic [15:0] cpu_wdata;
  logic        cpu_uds, cpu_lds, cpu_read, cpu_write;
  logic [15:0] cpu_rdata;
  logic        cpu_clk_en, cpu_berr;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int req_cycles = 0;

  // Model state: what the memory-side latches and the CPU read register hold.
  logic        m_we;
  logic [22:0] m_addr;
  logic [1:0]  m_be;
  logic [15:0] m_wdata, m_rdata;

  logic        exp_valid = 1'b0;
  logic        exp_clk_en, exp_berr, exp_req, exp_we;
  logic [22:0] exp_addr;
  logic [1:0]  exp_be;
  logic [15:0] exp_wdata, exp_rdata;

  always #5 clk = ~clk;

  m68k_bus_bridge #(
    .ADDR_W  (24),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_fc     (cpu_fc),
    .cpu_wdata  (cpu_wdata),
    .cpu_uds    (cpu_uds),
    .cpu_lds    (cpu_lds),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .cpu_clk_en (cpu_clk_en),
    .cpu_berr   (cpu_berr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cpu_clk_en", 32'(cpu_clk_en), 32'(exp_clk_en));
      chk("cpu_berr",   32'(cpu_berr),   32'(exp_berr));
      chk("mem_req",    32'(mem_req),    32'(exp_req));
      chk("mem_we",     32'(mem_we),     32'(exp_we));
      chk("mem_addr",   32'(mem_addr),   32'(exp_addr));
      chk("mem_be",     32'(mem_be),     32'(exp_be));
      chk("mem_wdata",  32'(mem_wdata),  32'(exp_wdata));
      chk("cpu_rdata",  32'(cpu_rdata),  32'(exp_rdata));
      if (mem_req === 1'b1) req_cycles++;
    end
  end

  task automatic set_exp(input logic clk_en, input logic berr, input logic req);
    exp_clk_en = clk_en;
    exp_berr   = berr;
    exp_req    = req;
    exp_we     = m_we;
    exp_addr   = m_addr;
    exp_be     = m_be;
    exp_wdata  = m_wdata;
    exp_rdata  = m_rdata;
    exp_valid  = 1'b1;
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_be = 2'b00; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_done();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_addr = '0; cpu_fc = 3'b001; cpu_wdata = '0;
    cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  // One CPU bus cycle starting in IDLE. ack_at is the 1-based WAIT cycle in
  // which memory acks (0 = never). stray drives mem_ack in the IDLE and DONE cycles.
  task automatic do_access(input logic [31:0] a, input logic [2:0] fc,
                           input logic uds, input logic lds,
                           input logic rd, input logic wr, input logic [15:0] wd,
                           input int ack_at, input logic [15:0] rdat, input logic stray);
    logic acc, err;
    int   n;
    acc = (!uds || !lds) && (rd != wr);
    next_cycle();
    cpu_addr = a; cpu_fc = fc; cpu_uds = uds; cpu_lds = lds;
    cpu_read = rd; cpu_write = wr; cpu_wdata = wd;
    mem_ack = stray; mem_rdata = 16'hDEAD;
    req_cycles = 0;
    set_exp(!acc, 1'b0, 1'b0);
    if (!acc) return;
    if (fc == 3'b111) begin
      next_cycle();
      mem_ack = stray;
      set_exp(1'b1, 1'b1, 1'b0);
      return;
    end
    m_addr = a[23:1]; m_we = wr; m_be = {!uds, !lds}; m_wdata = wd;
    err = !(ack_at >= 1 && ack_at <= TB_TIMEOUT);
    n   = err ? TB_TIMEOUT : ack_at;
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      mem_ack   = (i == ack_at);
      mem_rdata = (i == ack_at) ? rdat : 16'h5A5A;
      set_exp(1'b0, 1'b0, 1'b1);
    end
    if (err) m_rdata = 16'hFFFF;
    else if (rd) m_rdata = rdat;
    next_cycle();
    mem_ack = stray; mem_rdata = 16'hDEAD;
    set_exp(1'b1, err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cpu_idle();
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    set_exp(1'b0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    reset_n = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();

    // Word read, ack in the third WAIT cycle.
    do_access(32'h0000_0100, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3, 16'hBEEF, 1'b0);
    sample_done();
    chk("read_rdata", 32'(cpu_rdata), 32'h0000_BEEF);
    chk("read_addr",  32'(mem_addr),  32'h0000_0080);
    chk("read_be",    32'(mem_be),    32'h0000_0003);
    chk("read_berr",  32'(cpu_berr),  32'h0);
    chk("read_req_cycles", 32'(req_cycles), 32'd3);

    // Back-to-back byte write with stray acks around it.
    do_access(32'h0000_0201, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 2, 16'h0000, 1'b1);
    sample_done();
    chk("write_we",    32'(mem_we),    32'h1);
    chk("write_be",    32'(mem_be),    32'h0000_0001);
    chk("write_wdata", 32'(mem_wdata), 32'h0000_0055);
    chk("write_rdata_kept", 32'(cpu_rdata), 32'h0000_BEEF);

    // Zero-wait upper-byte read.
    do_access(32'h000A_BCDE, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h1357, 1'b0);
    sample_done();
    chk("zw_rdata", 32'(cpu_rdata), 32'h0000_1357);
    chk("zw_req_cycles", 32'(req_cycles), 32'd1);

    // Not accesses: both strobes high; read and write both high.
    do_access(32'h0000_0700, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h1111, 1'b1);
    do_access(32'h0000_0700, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 16'h1111, 1'b0);

    // Timeout on read.
    do_access(32'h0000_0300, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0);
    sample_done();
    chk("to_rdata", 32'(cpu_rdata), 32'h0000_FFFF);
    chk("to_berr",  32'(cpu_berr),  32'h1);
    chk("to_req_cycles", 32'(req_cycles), 32'd8);

    // Ack exactly in the expiry cycle.
    do_access(32'h0000_0400, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, TB_TIMEOUT, 16'h2468, 1'b0);
    sample_done();
    chk("edge_berr",  32'(cpu_berr),  32'h0);
    chk("edge_rdata", 32'(cpu_rdata), 32'h0000_2468);

    // CPU-space cycle.
    do_access(32'h0000_0500, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1, 16'h0000, 1'b0);
    sample_done();
    chk("fc7_berr", 32'(cpu_berr), 32'h1);
    chk("fc7_req",  32'(mem_req),  32'h0);

    // Write that times out.
    do_access(32'h0000_0802, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 0, 16'h0000, 1'b0);

    // Reset asserted mid-WAIT.
    next_cycle();
    cpu_addr = 32'h0000_0600; cpu_fc = 3'b001; cpu_wdata = 16'h0000;
    cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0;
    mem_ack = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    m_addr = 23'h000300; m_we = 1'b0; m_be = 2'b11; m_wdata = 16'h0000;
    repeat (2) begin
      next_cycle();
      set_exp(1'b0, 1'b0, 1'b1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'h0);
    model_reset();
    set_exp(1'b0, 1'b0, 1'b0);
    next_cycle();
    set_exp(1'b0, 1'b0, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    cpu_idle();
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();
    mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    sample_done();
    chk("post_rst_clk_en", 32'(cpu_clk_en), 32'h1);
    chk("post_rst_rdata",  32'(cpu_rdata),  32'h0);

    // Normal operation after reset.
    do_access(32'h0000_0002, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 16'hCAFE, 1'b0);
    sample_done();
    chk("recover_rdata", 32'(cpu_rdata), 32'h0000_CAFE);

    next_cycle();
    cpu_idle();
    mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();
    set_exp(1'b1, 1'b0, 1'b0);
    sample_done();
    exp_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
